// File: rtl/cv32e41s_pmp_rpm.sv
// cv32e41s_pmp_rpm - Region Protection Memory for the PMP trie walker.
//
// Two banks of RPM_DEPTH x 32-bit entries sharing one index:
//   bank 0 = CTRL/CFG, bank 1 = GUARD/ADDROFF.
// After reset, or on an init_i pulse, a sweep sequencer writes zero to every
// entry. Any entry that has not been programmed therefore has its CTRL valid
// bit clear.
//
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   imp_req_i/addr_i    walker read (1-cycle registered latency, no back-pressure)
//   imp_rvalid_o        walker read data valid
//   imp_rdata_b0/b1_o   walker read data, bank 0 / bank 1
//   addr_err_o          1-cycle pulse: walker address beyond RPM range
//   walker_busy_i       walker probing prefixes; stalls config writes
//   cfg_req/we/bank/index/wdata_i, cfg_gnt_o   config access handshake
//   cfg_rvalid_o/rdata_o                       config read return (1 cycle after gnt)
//   init_i              pulse: clear the whole store
//   init_done_o         store initialised and accessible
module cv32e41s_pmp_rpm #(
  parameter int RPM_DEPTH = 256,
  localparam int IDX_W    = $clog2(RPM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imp_req_i,
  input  logic [31:0]      imp_addr_i,
  output logic             imp_rvalid_o,
  output logic [31:0]      imp_rdata_b0_o,
  output logic [31:0]      imp_rdata_b1_o,
  input  logic             walker_busy_i,
  input  logic             cfg_req_i,
  input  logic             cfg_we_i,
  input  logic             cfg_bank_i,
  input  logic [IDX_W-1:0] cfg_index_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic             cfg_gnt_o,
  output logic             cfg_rvalid_o,
  output logic [31:0]      cfg_rdata_o,
  input  logic             init_i,
  output logic             init_done_o,
  output logic             addr_err_o
);

  typedef enum logic {INIT, READY} state_e;

  state_e             r_state, w_state_d;
  logic [IDX_W-1:0]   r_cnt, w_cnt_d;
  logic               w_init_we;

  logic [31:0]        r_mem_b0 [RPM_DEPTH];
  logic [31:0]        r_mem_b1 [RPM_DEPTH];

  logic               r_imp_rvalid, r_addr_err, r_cfg_rvalid;
  logic [31:0]        r_imp_b0, r_imp_b1, r_cfg_rdata;

  logic [IDX_W-1:0]   w_imp_idx;
  logic               w_oob, w_ready, w_cfg_wr, w_cfg_rd;
  logic               w_unused;

  // Byte-offset bits of the walker address carry no information.
  assign w_unused  = ^imp_addr_i[1:0];
  assign w_imp_idx = imp_addr_i[IDX_W+1:2];
  assign w_oob     = |imp_addr_i[31:IDX_W+2];
  assign w_ready   = (r_state == READY);

  // init_i takes priority over any config access in the same cycle.
  assign w_cfg_wr  = cfg_req_i &  cfg_we_i & w_ready & ~walker_busy_i & ~init_i;
  assign w_cfg_rd  = cfg_req_i & ~cfg_we_i & w_ready & ~init_i;
  assign cfg_gnt_o = w_cfg_wr | w_cfg_rd;

  // ---------------- init sequencer FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_init_we = 1'b0;
    case (r_state)
      INIT: begin
        w_init_we = 1'b1;
        if (init_i) begin
          w_cnt_d = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == IDX_W'(RPM_DEPTH - 1)) w_state_d = READY;
        end
      end
      READY: begin
        if (init_i) begin
          w_state_d = INIT;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = INIT;
    endcase
  end

  assign init_done_o = w_ready;

  // ---------------- storage (not reset; the sweep clears it) ----------------
  // Sweep and config writes are mutually exclusive because grants require READY.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem_b0[r_cnt] <= '0;
      r_mem_b1[r_cnt] <= '0;
    end else if (w_cfg_wr) begin
      if (cfg_bank_i) r_mem_b1[cfg_index_i] <= cfg_wdata_i;
      else            r_mem_b0[cfg_index_i] <= cfg_wdata_i;
    end
  end

  // ---------------- walker read port ----------------
  // Reading the array with non-blocking semantics gives read-before-write when
  // a config write hits the same index in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imp_rvalid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_imp_b0     <= '0;
      r_imp_b1     <= '0;
    end else if (w_ready) begin
      r_imp_rvalid <= imp_req_i;
      r_addr_err   <= imp_req_i & w_oob;
      if (imp_req_i) begin
        // Out-of-range addresses return an all-zero (invalid) entry.
        r_imp_b0 <= w_oob ? 32'h0 : r_mem_b0[w_imp_idx];
        r_imp_b1 <= w_oob ? 32'h0 : r_mem_b1[w_imp_idx];
      end
    end else begin
      r_imp_rvalid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_imp_b0     <= '0;
      r_imp_b1     <= '0;
    end
  end

  assign imp_rvalid_o   = r_imp_rvalid;
  assign imp_rdata_b0_o = r_imp_b0;
  assign imp_rdata_b1_o = r_imp_b1;
  assign addr_err_o     = r_addr_err;

  // ---------------- config read port ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_rvalid <= 1'b0;
      r_cfg_rdata  <= '0;
    end else begin
      r_cfg_rvalid <= w_cfg_rd;
      if (w_cfg_rd) r_cfg_rdata <= cfg_bank_i ? r_mem_b1[cfg_index_i] : r_mem_b0[cfg_index_i];
    end
  end

  assign cfg_rvalid_o = r_cfg_rvalid;
  assign cfg_rdata_o  = r_cfg_rdata;

endmodule
